// File: rtl/collatz_sweep_ctrl.sv
// Sweep sequencer for the Collatz iteration core: runs every N in [n_first, n_last]
// through the core and keeps the largest iteration count, with a per-run watchdog.
module collatz_sweep_ctrl #(
    parameter int unsigned N_W     = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [N_W-1:0]   n_first,
    input  logic [N_W-1:0]   n_last,
    output logic             core_start,
    output logic [N_W-1:0]   core_n,
    input  logic             core_busy,
    input  logic [CNT_W-1:0] core_count,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] max_count,
    output logic [N_W-1:0]   max_n,
    output logic [N_W:0]     runs,
    output logic             err_range,
    output logic             err_timeout
);

    localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned RUNS_W = N_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N_W-1:0]   cur;
    logic [N_W-1:0]   last;
    logic [TMR_W-1:0] timer;

    logic range_bad_c;
    logic at_last_c;
    logic expired_c;
    logic new_max_c;

    assign range_bad_c = (n_first == '0) || (n_first > n_last);
    assign at_last_c   = (cur == last);
    assign expired_c   = (timer == TMR_W'(TIMEOUT - 1));
    assign new_max_c   = (core_count > max_count);
    assign core_n      = cur;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a core handshake on the same edge as expiry wins over the watchdog
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = range_bad_c ? FINISH : DRAIN;
                end
            end
            DRAIN: begin
                if (!core_busy) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                if (core_busy) begin
                    state_nxt = RUN;
                end else if (expired_c) begin
                    state_nxt = FINISH;
                end
            end
            RUN: begin
                if (!core_busy) begin
                    state_nxt = at_last_c ? FINISH : DRAIN;
                end else if (expired_c) begin
                    state_nxt = FINISH;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs decoded straight from the state register
    always_comb begin
        core_start = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE:    busy       = 1'b0;
            LAUNCH:  core_start = 1'b1;
            FINISH:  done       = 1'b1;
            default: ;
        endcase
    end

    // Operand sequencing, watchdog timer and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= '0;
            last        <= '0;
            timer       <= '0;
            max_count   <= '0;
            max_n       <= '0;
            runs        <= '0;
            err_range   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        max_count   <= '0;
                        max_n       <= '0;
                        runs        <= '0;
                        err_timeout <= 1'b0;
                        err_range   <= range_bad_c;
                        if (!range_bad_c) begin
                            cur  <= n_first;
                            last <= n_last;
                        end
                    end
                end
                DRAIN: begin
                    timer <= '0;
                end
                LAUNCH: begin
                    timer <= timer + TMR_W'(1);
                    if (!core_busy && expired_c) begin
                        err_timeout <= 1'b1;
                    end
                end
                RUN: begin
                    timer <= timer + TMR_W'(1);
                    if (!core_busy) begin
                        runs <= runs + RUNS_W'(1);
                        if (new_max_c) begin
                            max_count <= core_count;
                            max_n     <= cur;
                        end
                        // Last-check before increment keeps cur from wrapping at the top value
                        if (!at_last_c) begin
                            cur <= cur + N_W'(1);
                        end
                    end else if (expired_c) begin
                        err_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// Bench for collatz_sweep_ctrl: behavioural core model, directed cases from the
// test plan, then randomized sweeps checked against a loop-based reference.
module tb_collatz_sweep_ctrl;

    localparam int unsigned N_W     = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMEOUT = 15;

    logic             clk;
    logic             rst_n;
    logic             go;
    logic [N_W-1:0]   n_first;
    logic [N_W-1:0]   n_last;
    logic             core_start;
    logic [N_W-1:0]   core_n;
    logic             core_busy;
    logic [CNT_W-1:0] core_count;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] max_count;
    logic [N_W-1:0]   max_n;
    logic [N_W:0]     runs;
    logic             err_range;
    logic             err_timeout;

    collatz_sweep_ctrl #(.N_W(N_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .n_first(n_first), .n_last(n_last),
        .core_start(core_start), .core_n(core_n), .core_busy(core_busy),
        .core_count(core_count), .busy(busy), .done(done), .max_count(max_count),
        .max_n(max_n), .runs(runs), .err_range(err_range), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Behavioural core: accepts start when idle, busy for lat cycles, count from table
    int         cnt_tab [0:255];
    int         lat;
    bit         dead;
    bit         f_busy;
    logic       m_busy;
    int         m_left;
    logic [7:0] m_cnt;
    int         launched_q[$];

    assign core_busy  = m_busy | f_busy;
    assign core_count = m_cnt;

    always @(posedge clk) begin
        if (m_busy) begin
            if (m_left <= 1) m_busy <= 1'b0;
            else             m_left <= m_left - 1;
        end else if (core_start && !dead) begin
            m_busy <= 1'b1;
            m_left <= lat;
            m_cnt  <= 8'(cnt_tab[core_n]);
            launched_q.push_back(int'(core_n));
        end
    end

    // Negedge monitors: start cycles, done pulses, protocol violations
    int start_cyc  = 0;
    int done_cnt   = 0;
    int viol_start = 0;
    int viol_done  = 0;
    bit prev_sb    = 0;
    bit prev_done  = 0;

    always @(negedge clk) begin
        if (core_start) start_cyc++;
        if (done) done_cnt++;
        if (core_start && core_busy && prev_sb) viol_start++;
        if (done && prev_done) viol_done++;
        prev_sb   = core_start && core_busy;
        prev_done = done;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    int d0;
    int s0;
    int cyc;

    // Issue one sweep; optional stray go mid-sweep, optional release of forced busy
    task automatic run_sweep(input int first, input int last, input bit bogus_go, input int release_at);
        launched_q.delete();
        d0 = done_cnt;
        s0 = start_cyc;
        n_first = 8'(first);
        n_last  = 8'(last);
        go = 1'b1;
        step();
        go  = 1'b0;
        cyc = 1;
        while (!done && cyc < 3000) begin
            go = 1'b0;
            if (bogus_go && cyc == 6) begin
                go = 1'b1;
                n_first = 8'd9;
                n_last  = 8'd3;
            end
            if (cyc == release_at) begin
                chk("drain_hold_no_start", start_cyc - s0, 0);
                chk("drain_hold_busy", 32'(busy), 1);
                f_busy = 1'b0;
            end
            step();
            cyc++;
        end
        go = 1'b0;
        if (!done) chk("done_wait_expired", 0, 1);
        step();
    endtask

    // Reference: walk the range with plain arithmetic
    task automatic check_sweep(input string tag, input int first, input int last);
        int r_runs = 0;
        int r_max  = 0;
        int r_maxn = 0;
        bit r_err;
        r_err = (first == 0) || (first > last);
        if (!r_err) begin
            for (int n = first; n <= last; n++) begin
                r_runs++;
                if (cnt_tab[n] > r_max) begin
                    r_max  = cnt_tab[n];
                    r_maxn = n;
                end
            end
        end
        chk({tag, "_runs"}, 32'(runs), r_runs);
        chk({tag, "_max_count"}, 32'(max_count), r_max);
        chk({tag, "_max_n"}, 32'(max_n), r_maxn);
        chk({tag, "_err_range"}, 32'(err_range), 32'(r_err));
        chk({tag, "_err_timeout"}, 32'(err_timeout), 0);
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_idle_after"}, 32'(busy), 0);
        chk({tag, "_launch_count"}, launched_q.size(), r_runs);
        for (int i = 0; i < launched_q.size() && i < r_runs; i++)
            chk({tag, "_core_n_order"}, launched_q[i], first + i);
        if (r_err) begin
            chk({tag, "_done_latency"}, cyc, 1);
            chk({tag, "_no_start"}, start_cyc - s0, 0);
        end
    endtask

    task automatic check_zero_outs(input string tag);
        chk({tag, "_core_start"}, 32'(core_start), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_results"}, {core_n, max_count, max_n, runs[7:0]}, 0);
        chk({tag, "_runs_msb_errs"}, {runs[8], err_range, err_timeout}, 0);
    endtask

    initial begin
        int first;
        int last;
        int kind;
        bit found;

        rst_n = 1'b0; go = 1'b0; n_first = '0; n_last = '0;
        dead = 0; f_busy = 0; lat = 10; m_busy = 1'b0; m_left = 0; m_cnt = '0;
        for (int i = 0; i < 256; i++) cnt_tab[i] = 0;
        repeat (3) step();
        check_zero_outs("reset");
        rst_n = 1'b1;
        step();

        // Normal sweep
        cnt_tab[5] = 5; cnt_tab[6] = 8; cnt_tab[7] = 16;
        run_sweep(5, 7, 0, -1);
        check_sweep("normal", 5, 7);

        // Tie keeps earlier N
        cnt_tab[3] = 9; cnt_tab[4] = 9; cnt_tab[5] = 4;
        lat = 3;
        run_sweep(3, 5, 0, -1);
        check_sweep("tie", 3, 5);

        // Range errors
        run_sweep(9, 3, 0, -1);
        check_sweep("range_rev", 9, 3);
        run_sweep(0, 4, 0, -1);
        check_sweep("range_zero", 0, 4);

        // Watchdog with a core that never answers
        dead = 1;
        run_sweep(20, 22, 0, -1);
        chk("tmo_err_timeout", 32'(err_timeout), 1);
        chk("tmo_runs", 32'(runs), 0);
        chk("tmo_start_cycles", start_cyc - s0, TIMEOUT);
        chk("tmo_done_pulses", done_cnt - d0, 1);
        chk("tmo_max_count", 32'(max_count), 0);
        dead = 0;
        cnt_tab[20] = 30; cnt_tab[21] = 7; cnt_tab[22] = 31;
        lat = 5;
        run_sweep(20, 22, 0, -1);
        check_sweep("post_tmo", 20, 22);

        // Top-of-range operand with core busy before and after go
        cnt_tab[255] = 42;
        f_busy = 1'b1;
        repeat (4) step();
        run_sweep(255, 255, 0, 4);
        check_sweep("boundary", 255, 255);

        // Asynchronous reset during RUN of N=6
        cnt_tab[5] = 11; cnt_tab[6] = 12; cnt_tab[7] = 13;
        lat = 10;
        launched_q.delete();
        n_first = 8'd5; n_last = 8'd7; go = 1'b1;
        step();
        go = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (core_n == 8'd6 && core_busy && !core_start && busy) found = 1;
            else step();
        end
        chk("rst_reached_run6", 32'(found), 1);
        chk("rst_pre_runs", 32'(runs), 1);
        #2 rst_n = 1'b0;
        #1 check_zero_outs("rst_async");
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("rst_idle_after_release", 32'(busy), 0);
        chk("rst_no_start_after_release", 32'(core_start), 0);

        // Stray go mid-sweep is ignored
        cnt_tab[2] = 50; cnt_tab[3] = 60; cnt_tab[4] = 55;
        lat = 4;
        run_sweep(2, 4, 1, -1);
        check_sweep("go_ignored", 2, 4);

        // Randomized sweeps
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                first = 0;
                last  = $urandom_range(0, 255);
            end else if (kind == 1) begin
                first = $urandom_range(2, 255);
                last  = $urandom_range(1, first - 1);
            end else begin
                first = $urandom_range(1, 255);
                last  = first + $urandom_range(0, 5);
                if (last > 255) last = 255;
            end
            for (int n = 0; n < 256; n++) cnt_tab[n] = $urandom_range(0, 255);
            lat = $urandom_range(1, 10);
            run_sweep(first, last, 0, -1);
            check_sweep("rand", first, last);
        end

        chk("start_drops_after_busy", viol_start, 0);
        chk("done_single_cycle", viol_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
